// File: rtl/rv_mem_if_pkg.sv
// Shared encodings for the load/store memory interface: access sizes, FSM states
// and the small helpers that turn a request into lane enables and lane data.
package rv_mem_if_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   // The reserved size encoding is rejected the same way as a misaligned address.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
      logic result;
      case (size)
         SZ_BYTE: result = 1'b0;
         SZ_HALF: result = offset[0];
         SZ_WORD: result = (offset != 2'b00);
         default: result = 1'b1;
      endcase
      return result;
   endfunction

   function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] offset);
      logic [3:0] result;
      case (size)
         SZ_BYTE: result = 4'b0001 << offset;
         SZ_HALF: result = 4'b0011 << offset;
         default: result = 4'b1111;
      endcase
      return result;
   endfunction

   function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] result;
      case (size)
         SZ_BYTE: result = {4{wdata[7:0]}};
         SZ_HALF: result = {2{wdata[15:0]}};
         default: result = wdata;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/rv_load_align.sv
// Moves the addressed bytes of a memory word down to bit 0, truncates to the
// access size and sign- or zero-extends the result.
module rv_load_align
   import rv_mem_if_pkg::*;
(
   input  logic [31:0] i_data,
   input  logic [1:0]  i_offset,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   output logic [31:0] o_result
);

   logic [31:0] w_shifted;
   logic        w_sign;

   always_comb begin
      w_shifted = i_data >> {i_offset, 3'b000};
      w_sign    = 1'b0;
      o_result  = w_shifted;
      case (i_size)
         SZ_BYTE: begin
            w_sign   = ~i_unsigned & w_shifted[7];
            o_result = {{24{w_sign}}, w_shifted[7:0]};
         end
         SZ_HALF: begin
            w_sign   = ~i_unsigned & w_shifted[15];
            o_result = {{16{w_sign}}, w_shifted[15:0]};
         end
         default: o_result = w_shifted;
      endcase
   end

endmodule

// File: rtl/rv_mem_if.sv
// Load/store unit front end: accepts one core request, drives a single memory
// access with byte enables, and returns extended load data or an error pulse.
module rv_mem_if
   import rv_mem_if_pkg::*;
#(
   parameter int TIMEOUT = 16
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic [1:0]  r_size;
   logic [1:0]  r_off;
   logic        r_unsigned;
   logic [31:0] w_load;

   rv_load_align u_align (
      .i_data     (mem_rdata),
      .i_offset   (r_off),
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .o_result   (w_load)
   );

   // The requester must stall in the very cycle it raises req_valid.
   assign busy = (r_state != ST_IDLE) || req_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_size     <= '0;
         r_off      <= '0;
         r_unsigned <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_rdata  <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_be     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  if (is_misaligned(req_size, req_addr[1:0])) begin
                     r_state <= ST_RESP;
                     rsp_err <= 1'b1;
                  end else begin
                     r_state    <= ST_ACCESS;
                     r_cnt      <= '0;
                     r_size     <= req_size;
                     r_off      <= req_addr[1:0];
                     r_unsigned <= req_unsigned;
                     mem_req    <= 1'b1;
                     mem_we     <= req_we;
                     mem_addr   <= {req_addr[31:2], 2'b00};
                     mem_wdata  <= lane_data(req_size, req_wdata);
                     mem_be     <= byte_enables(req_size, req_addr[1:0]);
                  end
               end
            end
            ST_ACCESS: begin
               // An ack in the final allowed cycle still completes normally.
               if (mem_ack || (r_cnt == LP_LAST)) begin
                  r_state   <= ST_RESP;
                  rsp_valid <= mem_ack;
                  rsp_err   <= ~mem_ack;
                  rsp_rdata <= (mem_ack && !mem_we) ? w_load : 32'd0;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_addr  <= '0;
                  mem_wdata <= '0;
                  mem_be    <= '0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            ST_RESP: begin
               r_state   <= ST_IDLE;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
